// File: rtl/alu_issue_seq.sv
// Issue sequencer for an external 32-bit combinational ALU: decodes one MIPS op, waits ALU_LAT cycles, returns result.
// Optional signed-overflow reporting for ADD/SUB/ADDI is compiled in with ALU_ISSUE_OVF_EN.
module alu_issue_seq #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_binvert,
  output logic        alu_cin,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic        alu_co,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_ovf,
  output logic        out_err
);

  // state | meaning
  // IDLE  | ready for a new instruction
  // EXEC  | alu_* held, down-counting to terminal count
  // DONE  | result presented until out_ready
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          tc;
  logic          is_slt_q, is_err_q;

  logic [31:0] dec_a, dec_b;
  logic        dec_binv, dec_cin, dec_slt, dec_err;
  logic [1:0]  dec_op;
  logic [31:0] b_eff, res_fin;
  logic        vraw;
  logic        unused_co;

  assign unused_co = alu_co;
  assign tc        = (cnt == '0);

  always_comb begin
    dec_a    = in_rs_val;
    dec_b    = in_rt_val;
    dec_binv = 1'b0;
    dec_cin  = 1'b0;
    dec_op   = 2'b10;
    dec_slt  = 1'b0;
    dec_err  = 1'b0;
    case (in_opcode)
      6'h00: begin
        case (in_funct)
          6'h20, 6'h21: ;
          6'h22, 6'h23: begin dec_binv = 1'b1; dec_cin = 1'b1; end
          6'h24: dec_op = 2'b00;
          6'h25: dec_op = 2'b01;
          6'h2A: begin dec_binv = 1'b1; dec_cin = 1'b1; dec_slt = 1'b1; end
          default: dec_err = 1'b1;
        endcase
      end
      6'h08, 6'h09: dec_b = {{16{in_imm[15]}}, in_imm};
      6'h0C: begin dec_b = {16'b0, in_imm}; dec_op = 2'b00; end
      6'h0D: begin dec_b = {16'b0, in_imm}; dec_op = 2'b01; end
      6'h0A: begin
        dec_b    = {{16{in_imm[15]}}, in_imm};
        dec_binv = 1'b1;
        dec_cin  = 1'b1;
        dec_slt  = 1'b1;
      end
      6'h04, 6'h05: begin dec_binv = 1'b1; dec_cin = 1'b1; end
      default: dec_err = 1'b1;
    endcase
    if (dec_err) begin
      dec_a    = '0;
      dec_b    = '0;
      dec_binv = 1'b0;
      dec_cin  = 1'b0;
      dec_op   = 2'b00;
      dec_slt  = 1'b0;
    end
  end

  // vraw is the signed overflow of a +/- b_eff; for SLT it corrects the sign bit
  assign b_eff   = alu_binvert ? ~alu_b : alu_b;
  assign vraw    = (alu_a[31] == b_eff[31]) && (alu_res[31] != alu_a[31]);
  assign res_fin = is_err_q ? 32'b0 :
                   is_slt_q ? {31'b0, alu_res[31] ^ vraw} : alu_res;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_EXEC;
      S_EXEC:  if (tc) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_binvert <= 1'b0;
      alu_cin     <= 1'b0;
      alu_op      <= 2'b00;
      is_slt_q    <= 1'b0;
      is_err_q    <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          cnt         <= CW'(ALU_LAT - 1);
          alu_a       <= dec_a;
          alu_b       <= dec_b;
          alu_binvert <= dec_binv;
          alu_cin     <= dec_cin;
          alu_op      <= dec_op;
          is_slt_q    <= dec_slt;
          is_err_q    <= dec_err;
        end
        S_EXEC: begin
          if (tc) begin
            out_result <= res_fin;
            out_zero   <= (res_fin == 32'b0);
            out_err    <= is_err_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_OVF_EN
  logic dec_ovf, is_ovf_q, ovf_q;

  assign dec_ovf = ((in_opcode == 6'h00) && ((in_funct == 6'h20) || (in_funct == 6'h22)))
                   || (in_opcode == 6'h08);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_ovf_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      is_ovf_q <= dec_ovf;
    end else if (state == S_EXEC && tc) begin
      ovf_q <= is_ovf_q & vraw;
    end
  end

  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU, instruction-level reference model, directed plus random ops.
module tb_alu_issue_seq;
  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode, in_funct;
  logic [15:0] in_imm;
  logic [31:0] in_rs_val, in_rt_val;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_binvert, alu_cin, alu_co;
  logic [1:0]  alu_op;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_ovf, out_err;

  int total = 0;
  int bad   = 0;

  alu_issue_seq #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_imm(in_imm),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .alu_a(alu_a), .alu_b(alu_b), .alu_binvert(alu_binvert), .alu_cin(alu_cin),
    .alu_op(alu_op), .alu_res(alu_res), .alu_co(alu_co),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // external combinational ALU
  logic [31:0] bx;
  logic [32:0] sum;
  always_comb begin
    bx      = alu_binvert ? ~alu_b : alu_b;
    sum     = {1'b0, alu_a} + {1'b0, bx} + {32'b0, alu_cin};
    alu_res = sum[31:0];
    alu_co  = 1'b0;
    if (alu_op == 2'b00)      alu_res = alu_a & bx;
    else if (alu_op == 2'b01) alu_res = alu_a | bx;
    else                      alu_co  = sum[32];
  end

  function automatic bit ovf_of(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  function automatic void ref_model(input logic [5:0] opc, input logic [5:0] fn,
                                    input logic [15:0] imm, input logic [31:0] rs,
                                    input logic [31:0] rt, output logic [31:0] r,
                                    output logic z, output logic o, output logic e);
    longint srs, srt, ssx;
    logic [31:0] sx, zx;
    bit ov;
    srs = longint'($signed(rs));
    srt = longint'($signed(rt));
    sx  = {{16{imm[15]}}, imm};
    zx  = {16'b0, imm};
    ssx = longint'($signed(sx));
    r = 32'b0; e = 1'b0; ov = 1'b0;
    if (opc == 6'h00) begin
      case (fn)
        6'h20: begin r = rs + rt; ov = ovf_of(srs + srt); end
        6'h21: r = rs + rt;
        6'h22: begin r = rs - rt; ov = ovf_of(srs - srt); end
        6'h23: r = rs - rt;
        6'h24: r = rs & rt;
        6'h25: r = rs | rt;
        6'h2A: r = (srs < srt) ? 32'd1 : 32'd0;
        default: e = 1'b1;
      endcase
    end else begin
      case (opc)
        6'h08: begin r = rs + sx; ov = ovf_of(srs + ssx); end
        6'h09: r = rs + sx;
        6'h0C: r = rs & zx;
        6'h0D: r = rs | zx;
        6'h0A: r = (srs < ssx) ? 32'd1 : 32'd0;
        6'h04, 6'h05: r = rs - rt;
        default: e = 1'b1;
      endcase
    end
    z = (r == 32'b0);
`ifdef ALU_ISSUE_OVF_EN
    o = ov;
`else
    o = 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // issue one op starting at posedge+1, hold out_ready low for 'hold' extra cycles
  task automatic issue(input logic [5:0] opc, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt, input int hold);
    logic [31:0] er, s_res;
    logic        ez, eo, ee, s_z, s_o, s_e;
    bit          early, unstable;
    ref_model(opc, fn, imm, rs, rt, er, ez, eo, ee);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_opcode = opc; in_funct = fn; in_imm = imm;
    in_rs_val = rs; in_rt_val = rt; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
    early = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk); #1;
      if (out_valid) early = 1'b1;
    end
    chk("early_valid", {31'b0, early}, 32'd0);
    @(posedge clk); #1;
    chk("latency_valid", {31'b0, out_valid}, 32'd1);
    chk("result", out_result, er);
    chk("zero", {31'b0, out_zero}, {31'b0, ez});
    chk("ovf", {31'b0, out_ovf}, {31'b0, eo});
    chk("err", {31'b0, out_err}, {31'b0, ee});
    s_res = out_result; s_z = out_zero; s_o = out_ovf; s_e = out_err;
    unstable = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_result !== s_res || out_zero !== s_z ||
          out_ovf !== s_o || out_err !== s_e) unstable = 1'b1;
    end
    if (hold > 0) chk("backpressure_hold", {31'b0, unstable}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", {31'b0, out_valid}, 32'd0);
    chk("release_ready", {31'b0, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] c [6];
    c = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h0000FFFF};
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [5:0] ops [15];
    logic [5:0] fns [15];
    bit early;
    int sel;
    ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09,
            6'h0C, 6'h0D, 6'h0A, 6'h04, 6'h05, 6'h3F};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00,
            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct = '0; in_imm = '0; in_rs_val = '0; in_rt_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {28'b0, out_zero, out_ovf, out_err, alu_binvert}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(6'h00, 6'h20, 16'h0, 32'd5, 32'd3, 0);
    issue(6'h00, 6'h22, 16'h0, 32'd3, 32'd5, 0);
    issue(6'h04, 6'h00, 16'h0, 32'd1234, 32'd1234, 0);
    issue(6'h05, 6'h00, 16'h0, 32'd1, 32'd2, 0);
    issue(6'h00, 6'h2A, 16'h0, 32'h80000000, 32'd1, 0);
    issue(6'h0A, 6'h00, 16'hFFFF, 32'd1, 32'd0, 0);
    issue(6'h0C, 6'h00, 16'h8000, 32'hFFFFFFFF, 32'd0, 0);
    issue(6'h00, 6'h20, 16'h0, 32'h7FFFFFFF, 32'd1, 0);
    issue(6'h00, 6'h21, 16'h0, 32'h7FFFFFFF, 32'd1, 0);
    issue(6'h08, 6'h00, 16'h0001, 32'h7FFFFFFF, 32'd0, 0);
    issue(6'h00, 6'h22, 16'h0, 32'h80000000, 32'd1, 0);
    issue(6'h3F, 6'h00, 16'h1234, 32'hDEADBEEF, 32'h12345678, 0);
    issue(6'h00, 6'h25, 16'h0, 32'hF0F00000, 32'h00000F0F, 5);

    // reset while in EXEC abandons the op
    in_valid = 1'b1; in_opcode = 6'h00; in_funct = 6'h20;
    in_rs_val = 32'd10; in_rt_val = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", out_result, 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    early = 1'b0;
    repeat (LAT + 2) begin
      @(posedge clk); #1;
      if (out_valid) early = 1'b1;
    end
    chk("midrst_no_valid", {31'b0, early}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 15);
      if (sel == 15)
        issue(6'h00, 6'($urandom_range(0, 31)), 16'($urandom), rnd_operand(), rnd_operand(),
              $urandom_range(0, 3));
      else
        issue(ops[sel], fns[sel], 16'($urandom), rnd_operand(), rnd_operand(),
              $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
